reg_file_32x32: RTL and testbench
=================================

// Module: reg_file_32x32
// PURPOSE
//  - General-purpose register file for the datapath: 32 registers x DATA_W bits, two async read ports, one sync write port.
//  - Sits directly downstream of the 5-bit 4:1 write-address mux. That mux output (rt / rd / $31 / spare) drives wa here.
//  - $0 is hardwired to zero.
//  - Adds optional write-to-read bypass, a debug read port for the display, and a committed-write counter.
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W    5  address width (fixed 2**ADDR_W = 32 registers)
//  BYPASS    1  1 = read of the address being written this cycle returns wd; 0 = returns old contents
//  CNT_W    16  width of committed-write counter
// PORTS
//  clk     in   1        clock, rising edge active
//  rst     in   1        asynchronous reset, active-high
//  we      in   1        write enable, sampled on rising clk
//  wa      in   ADDR_W   write address (from 4:1 address mux output o)
//  wd      in   DATA_W   write data
//  ra1     in   ADDR_W   read address, port 1
//  rd1     out  DATA_W   read data, port 1 (combinational)
//  ra2     in   ADDR_W   read address, port 2
//  rd2     out  DATA_W   read data, port 2 (combinational)
//  dbg_a   in   ADDR_W   debug read address
//  dbg_d   out  DATA_W   debug read data (combinational, never bypassed)
//  wr_cnt  out  CNT_W    number of committed writes to regs 1..31 since reset
// BEHAVIOUR
//  - Clock/reset: one clock (clk); rst is asynchronous, active-high.
//  - Reset: while rst=1, regs[0..31]=0 and wr_cnt=0 immediately, without waiting for clk.
//      Consequence: rd1/rd2/dbg_d read 0 during reset (bypass masked while rst=1).
//  - Reset release: first write can commit on the first rising clk with rst=0.
//  - Write: on rising clk with rst=0, we=1, wa!=0:
//      regs[wa] <= wd; wr_cnt <= wr_cnt+1. Latency 1 cycle.
//  - Write to $0: we=1, wa=0 is accepted but discarded. regs[0] stays 0, wr_cnt unchanged.
//  - we=0: no register changes, wr_cnt holds.
//  - Read: rdN = (raN==0) ? 0 : regs[raN], pure combinational, zero latency.
//  - Bypass (BYPASS=1): if we=1, rst=0, wa!=0 and raN==wa, then rdN = wd in the same cycle.
//      Both read ports bypass independently; ra1==ra2==wa gives wd on both.
//  - BYPASS=0: rdN shows old value until the edge, new value after.
//  - dbg_d: dbg_a==0 ? 0 : regs[dbg_a]. Never bypassed. Shows committed state only.
//  - wr_cnt arithmetic: unsigned, wraps 2**CNT_W-1 -> 0 with no flag.
//  - Reset mid-operation: rst asserted in the same cycle as we=1 means the write is lost.
//      All regs=0 and wr_cnt=0 immediately; next cycle reads 0.
//  - No X propagation: every output is defined for any input once rst has been applied.
// TESTING
//  1. rst=1 for 2 cycles, then 0 -> rd1, rd2, dbg_d = 0 for all addresses; wr_cnt=0.
//  2. we=1, wa=5'd3, wd=32'hDEAD_BEEF, one edge; then ra1=3
//      -> rd1=32'hDEAD_BEEF, dbg_d(dbg_a=3)=32'hDEAD_BEEF, wr_cnt=1.
//  3. we=1, wa=0, wd=32'hFFFF_FFFF, one edge; ra1=0
//      -> rd1=0, wr_cnt unchanged.
//  4. BYPASS=1: regs[10]=32'h1, then we=1, wa=10, wd=32'h55, ra1=ra2=10 before edge
//      -> rd1=rd2=32'h55, dbg_d(dbg_a=10)=32'h1; after edge dbg_d=32'h55.
//  5. Write regs 31 (=32'h0A) and 1 (=32'h05), then pulse rst mid-cycle with we=1, wa=2
//      -> regs 1/2/31 read 0 immediately; wr_cnt=0.
//  6. Sweep wa=1..31 with wd=wa*32'h0101_0101, then read both ports across all addresses
//      -> every read matches; wr_cnt=31; no cross-register corruption.

Source files
------------

// File: rtl/reg_file_32x32.sv
// General-purpose 32-entry register file: two combinational read ports, one
// synchronous write port, optional write-to-read bypass, debug port, write counter.
module reg_file_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_a,
  output logic [DATA_W-1:0] dbg_d,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_d;
  logic              wr_en;

  // Writes to $0 are swallowed here so neither the array nor the counter sees them.
  assign wr_en    = we && (wa != '0);
  assign wr_cnt_d = wr_en ? wr_cnt_q + 1'b1 : wr_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[wa] <= wd;
      end
      wr_cnt_q <= wr_cnt_d;
    end
  end

  function automatic logic [DATA_W-1:0] committed(input logic [ADDR_W-1:0] a);
    return (a == '0) ? '0 : regs_q[a];
  endfunction

  // Bypass is gated by rst so reads stay zero for the whole reset interval.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    if (BYPASS && wr_en && !rst && (a == wa)) begin
      return wd;
    end
    return committed(a);
  endfunction

  assign rd1    = read_port(ra1);
  assign rd2    = read_port(ra2);
  assign dbg_d  = committed(dbg_a);
  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed self-checking bench for reg_file_32x32 with default parameters
// (DATA_W=32, ADDR_W=5, BYPASS=1, CNT_W=16).
module tb_reg_file_32x32;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [31:0] rd1;
  logic [4:0]  ra2;
  logic [31:0] rd2;
  logic [4:0]  dbg_a;
  logic [31:0] dbg_d;
  logic [15:0] wr_cnt;

  int checks;
  int errors;

  reg_file_32x32 #(
    .DATA_W(32),
    .ADDR_W(5),
    .BYPASS(1'b1),
    .CNT_W (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .ra1   (ra1),
    .rd1   (rd1),
    .ra2   (ra2),
    .rd2   (rd2),
    .dbg_a (dbg_a),
    .dbg_d (dbg_d),
    .wr_cnt(wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    we = 1'b0; wa = '0; wd = '0;
    ra1 = '0; ra2 = '0; dbg_a = '0;

    // 1: reset for two cycles, everything reads zero
    #1;
    we = 1'b1; wa = 5'd7; wd = 32'h1234_5678; ra1 = 5'd7; ra2 = 5'd7; dbg_a = 5'd7;
    #1;
    check("rst_bypass_masked_rd1", rd1, 32'h0);
    check("rst_bypass_masked_rd2", rd2, 32'h0);
    tick();
    tick();
    we = 1'b0;
    rst = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a); dbg_a = 5'(a);
      #1;
      check("reset_rd1", rd1, 32'h0);
      check("reset_rd2", rd2, 32'h0);
      check("reset_dbg", dbg_d, 32'h0);
    end
    check("reset_cnt", 32'(wr_cnt), 32'd0);

    // 2: basic write to $3
    write_reg(5'd3, 32'hDEAD_BEEF);
    ra1 = 5'd3; dbg_a = 5'd3;
    #1;
    check("w3_rd1", rd1, 32'hDEAD_BEEF);
    check("w3_dbg", dbg_d, 32'hDEAD_BEEF);
    check("w3_cnt", 32'(wr_cnt), 32'd1);

    // 3: write to $0 discarded, and never bypassed
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    check("w0_nobypass_rd1", rd1, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("w0_rd1", rd1, 32'h0);
    check("w0_rd2", rd2, 32'h0);
    check("w0_cnt", 32'(wr_cnt), 32'd1);

    // 4: bypass on both ports, debug port shows committed value
    write_reg(5'd10, 32'h1);
    we = 1'b1; wa = 5'd10; wd = 32'h55; ra1 = 5'd10; ra2 = 5'd10; dbg_a = 5'd10;
    #1;
    check("byp_rd1", rd1, 32'h55);
    check("byp_rd2", rd2, 32'h55);
    check("byp_dbg_old", dbg_d, 32'h1);
    ra2 = 5'd3;
    #1;
    check("byp_other_rd2", rd2, 32'hDEAD_BEEF);
    tick();
    we = 1'b0;
    #1;
    check("byp_dbg_new", dbg_d, 32'h55);
    check("byp_cnt", 32'(wr_cnt), 32'd3);

    // 5: reset mid-cycle with a write pending
    write_reg(5'd31, 32'h0A);
    write_reg(5'd1, 32'h05);
    ra1 = 5'd1; ra2 = 5'd31;
    #1;
    check("pre_rst_rd1", rd1, 32'h05);
    check("pre_rst_rd2", rd2, 32'h0A);
    check("pre_rst_cnt", 32'(wr_cnt), 32'd5);
    we = 1'b1; wa = 5'd2; wd = 32'h77; ra2 = 5'd2; dbg_a = 5'd31;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rd1", rd1, 32'h0);
    check("midrst_rd2_bypass_masked", rd2, 32'h0);
    check("midrst_dbg31", dbg_d, 32'h0);
    check("midrst_cnt", 32'(wr_cnt), 32'd0);
    tick();
    rst = 1'b0;
    we = 1'b0;
    tick();
    dbg_a = 5'd2;
    #1;
    check("post_rst_rd2", rd2, 32'h0);
    check("post_rst_dbg2", dbg_d, 32'h0);
    check("post_rst_cnt", 32'(wr_cnt), 32'd0);

    // 6: fill every register and read all of them back on every port
    for (int a = 1; a < 32; a++) begin
      write_reg(5'(a), 32'(a) * 32'h0101_0101);
    end
    #1;
    check("sweep_cnt", 32'(wr_cnt), 32'd31);
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a); dbg_a = 5'(a);
      #1;
      check("sweep_rd1", rd1, 32'(a) * 32'h0101_0101);
      check("sweep_rd2", rd2, 32'(31 - a) * 32'h0101_0101);
      check("sweep_dbg", dbg_d, 32'(a) * 32'h0101_0101);
    end

    // we=0 holds everything
    wa = 5'd4; wd = 32'hCAFE_F00D; ra1 = 5'd4;
    tick();
    #1;
    check("hold_rd1", rd1, 32'h0404_0404);
    check("hold_cnt", 32'(wr_cnt), 32'd31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
